axi_read_intf: RTL

AXI4 read-channel slave that is the read-side counterpart to the block's AXI write interface. It accepts one AR burst at a time, issues one internal read request per beat to the FIFO/IRAM/WRAM targets selected by ARREGION, and returns each beat on the R channel with RID, RRESP and RLAST. Internal targets answer with a one-cycle data-valid pulse; the block holds R-channel outputs stable under RREADY backpressure.

---
 rtl/axi_read_intf.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi_read_intf.sv
// AXI4 read-channel slave: one AR burst at a time, one internal read request per beat,
// each beat returned on R with RID/RRESP/RLAST and held stable under RREADY backpressure.
module axi_read_intf #(
    parameter int ARID_WIDTH   = 8,
    parameter int ARADDR_WIDTH = 11,
    parameter int RDATA_WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ARID_WIDTH-1:0]   ARID,
    input  logic [ARADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [3:0]              ARREGION,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ARID_WIDTH-1:0]   RID,
    output logic [RDATA_WIDTH-1:0]  RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    axi_rd_req,
    output logic [ARADDR_WIDTH-1:0] axi_rd_addr,
    output logic [1:0]              axi_rd_region,
    input  logic                    rd_data_vld,
    input  logic [RDATA_WIDTH-1:0]  rd_data,
    input  logic                    rd_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                  state_q, state_d;
    logic [ARID_WIDTH-1:0]   id_q, id_d;
    logic [ARADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [2:0]              size_q, size_d;
    logic                    fixed_q, fixed_d;
    logic [1:0]              region_q, region_d;
    logic                    err_q, err_d;
    logic [RDATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic                    rvalid_q, rvalid_d;
    logic [ARADDR_WIDTH-1:0] addr_step;

    // INCR step is 1<<size; the add truncates so addresses wrap at the top of the space.
    assign addr_step = ARADDR_WIDTH'(1) << size_q;

    assign ARREADY       = (state_q == S_IDLE);
    assign RID           = id_q;
    assign RDATA         = rdata_q;
    assign RRESP         = rresp_q;
    assign RLAST         = rlast_q;
    assign RVALID        = rvalid_q;
    assign axi_rd_req    = (state_q == S_REQ) && !err_q;
    assign axi_rd_addr   = addr_q;
    assign axi_rd_region = region_q;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        fixed_d  = fixed_q;
        region_d = region_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rvalid_d = rvalid_q;

        case (state_q)
            S_IDLE: begin
                if (ARVALID) begin
                    id_d     = ARID;
                    addr_d   = ARADDR;
                    cnt_d    = ARLEN;
                    size_d   = ARSIZE;
                    fixed_d  = (ARBURST == 2'b00);
                    region_d = ARREGION[1:0];
                    err_d    = (ARREGION[1:0] == 2'b11) || (ARSIZE > 3'd3);
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                // Unmapped region or oversized beat: answer SLVERR without touching the targets.
                if (err_q) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    rlast_d  = (cnt_q == 8'd0);
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rd_data_vld) begin
                    rdata_d  = rd_data;
                    rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d  = (cnt_q == 8'd0);
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (RREADY) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        if (!fixed_q) begin
                            addr_d = addr_q + addr_step;
                        end
                        state_d = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            size_q   <= '0;
            fixed_q  <= 1'b0;
            region_q <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            fixed_q  <= fixed_d;
            region_q <= region_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule
